param_counter: RTL and testbench

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/counter_pkg.sv | 7 +
 rtl/counter_prescaler.sv | 27 ++
 rtl/param_counter.sv | 99 +++++++++
 tb/tb_param_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the parameterised up/down counter.
package counter_pkg;
   localparam logic MODE_WRAP        = 1'b0;
   localparam logic MODE_SAT         = 1'b1;
   localparam int   DEFAULT_WIDTH    = 4;
   localparam int   DEFAULT_PRESCALE = 4;
endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE; strobe marks the enabled cycle at phase PRESCALE-1.
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = DEFAULT_PRESCALE
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic strobe
);
   localparam int            CW   = $clog2(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= (count_reg == LAST) ? '0 : count_reg + CW'(1);
      end
   end

   assign strobe = enable && (count_reg == LAST);
endmodule

// File: rtl/param_counter.sv
// Up/down counter with wrap/saturate boundary, terminal-count pulse and sticky overflow.
// Optional step prescaler enabled by defining COUNTER_PRESCALE_EN.
module param_counter
   import counter_pkg::*;
#(
   parameter int              WIDTH    = DEFAULT_WIDTH,
   parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
   parameter int              PRESCALE = DEFAULT_PRESCALE
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] counter_out,
   output logic             tc,
   output logic             ovf
);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("param_counter: WIDTH out of range");
   end
   if (MAX < 1 || MAX > (64'd1 << WIDTH) - 64'd1) begin : g_bad_max
      $error("param_counter: MAX out of range");
   end
   if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
      $error("param_counter: PRESCALE out of range");
   end

   logic [WIDTH-1:0] count_reg, count_next;
   logic             tc_reg, tc_next;
   logic             ovf_reg, ovf_next;
   logic             step;

`ifdef COUNTER_PRESCALE_EN
   logic strobe;

   counter_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clock  (clock),
      .reset  (reset),
      .clear  (load),
      .enable (enable),
      .strobe (strobe)
   );

   assign step = strobe && !load;
`else
   assign step = enable && !load;
`endif

   always_comb begin
      count_next = count_reg;
      tc_next    = 1'b0;
      ovf_next   = ovf_reg;
      if (load) begin
         count_next = (load_value > MAX_V) ? MAX_V : load_value;
         ovf_next   = 1'b0;
      end else if (step) begin
         if (up) begin
            if (count_reg == MAX_V) begin
               tc_next    = 1'b1;
               count_next = (sat_mode == MODE_WRAP) ? '0 : MAX_V;
            end else begin
               count_next = count_reg + WIDTH'(1);
            end
         end else begin
            if (count_reg == '0) begin
               tc_next    = 1'b1;
               count_next = (sat_mode == MODE_WRAP) ? MAX_V : '0;
            end else begin
               count_next = count_reg - WIDTH'(1);
            end
         end
         // A boundary step sets the sticky flag on the same edge as the tc pulse.
         ovf_next = ovf_reg | tc_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg <= '0;
         tc_reg    <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         count_reg <= count_next;
         tc_reg    <= tc_next;
         ovf_reg   <= ovf_next;
      end
   end

   assign counter_out = count_reg;
   assign tc          = tc_reg;
   assign ovf         = ovf_reg;
endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: directed vector table, corner sequences and random stimulus vs model.
module tb_param_counter;
   import counter_pkg::*;

   localparam int PS = 4;
`ifdef COUNTER_PRESCALE_EN
   localparam int PSE = PS;
`else
   localparam int PSE = 1;
`endif

   typedef struct {
      int cnt;
      bit tc;
      bit ovf;
      int ps;
   } mstate_t;

   typedef struct {
      bit rst;
      bit ld;
      int lv;
      bit en;
      bit up;
      bit sat;
      int cnt;
      bit tc;
      bit ovf;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset, enable, up, load, sat_mode;
   logic [3:0] load_value;
   logic [3:0] count_a, count_b;
   logic       tc_a, tc_b, ovf_a, ovf_b;

   int      checks = 0;
   int      errors = 0;
   mstate_t ma, mb;
   vec_t    vecs[$];

   always #5 clock = ~clock;

   param_counter #(.WIDTH(4), .PRESCALE(PS)) dut_a (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_value(load_value), .sat_mode(sat_mode),
      .counter_out(count_a), .tc(tc_a), .ovf(ovf_a)
   );

   param_counter #(.WIDTH(4), .MAX(9), .PRESCALE(PS)) dut_b (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_value(load_value), .sat_mode(sat_mode),
      .counter_out(count_b), .tc(tc_b), .ovf(ovf_b)
   );

   // Reference behaviour: counting modulo mx+1, clamp or wrap at the ends.
   function automatic mstate_t mnext(mstate_t s, int mx, bit rst, bit ld, int lv,
                                     bit en, bit u, bit sat);
      mstate_t n = s;
      n.tc = 1'b0;
      if (rst) begin
         n = '{0, 1'b0, 1'b0, 0};
      end else if (ld) begin
         n.cnt = (lv > mx) ? mx : lv;
         n.ovf = 1'b0;
         n.ps  = 0;
      end else if (en) begin
         bit fire = (s.ps == PSE - 1);
         n.ps = (s.ps + 1) % PSE;
         if (fire) begin
            if (u) begin
               if (s.cnt == mx) begin
                  n.tc  = 1'b1;
                  n.cnt = sat ? mx : 0;
               end else n.cnt = s.cnt + 1;
            end else begin
               if (s.cnt == 0) begin
                  n.tc  = 1'b1;
                  n.cnt = sat ? 0 : mx;
               end else n.cnt = s.cnt - 1;
            end
            if (n.tc) n.ovf = 1'b1;
         end
      end
      return n;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic cycle(bit rst, bit ld, int lv, bit en, bit u, bit sat);
      reset      = rst;
      load       = ld;
      load_value = 4'(lv);
      enable     = en;
      up         = u;
      sat_mode   = sat;
      @(posedge clock);
      ma = mnext(ma, 15, rst, ld, lv, en, u, sat);
      mb = mnext(mb, 9, rst, ld, lv, en, u, sat);
      #1;
      check("model_a_count", 32'(count_a), 32'(ma.cnt));
      check("model_a_tc", 32'(tc_a), 32'(ma.tc));
      check("model_a_ovf", 32'(ovf_a), 32'(ma.ovf));
      check("model_b_count", 32'(count_b), 32'(mb.cnt));
      check("model_b_tc", 32'(tc_b), 32'(mb.tc));
      check("model_b_ovf", 32'(ovf_b), 32'(mb.ovf));
      $display("cycle rst=%0b ld=%0b lv=%0d en=%0b up=%0b sat=%0b -> a=%0d/%0b/%0b b=%0d/%0b/%0b",
               rst, ld, lv, en, u, sat, count_a, tc_a, ovf_a, count_b, tc_b, ovf_b);
   endtask

   initial begin
      ma = '{0, 1'b0, 1'b0, 0};
      mb = '{0, 1'b0, 1'b0, 0};
      reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0;
      sat_mode = MODE_WRAP; load_value = '0;

`ifndef COUNTER_PRESCALE_EN
      // Directed table against the MAX=9 instance.
      //          rst ld lv en up sat   cnt tc ovf
      vecs.push_back('{1, 0, 0, 0, 1, 0,   0, 0, 0});
      vecs.push_back('{0, 1, 7, 0, 1, 1,   7, 0, 0});
      vecs.push_back('{0, 0, 0, 1, 1, 1,   8, 0, 0});
      vecs.push_back('{0, 0, 0, 1, 1, 1,   9, 0, 0});
      vecs.push_back('{0, 0, 0, 1, 1, 1,   9, 1, 1});
      vecs.push_back('{0, 0, 0, 1, 1, 1,   9, 1, 1});
      vecs.push_back('{0, 0, 0, 0, 1, 1,   9, 0, 1});
      vecs.push_back('{0, 1, 0, 0, 0, 0,   0, 0, 0});
      vecs.push_back('{0, 0, 0, 1, 0, 0,   9, 1, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0,   9, 0, 1});
      vecs.push_back('{0, 1, 12, 0, 0, 0,  9, 0, 0});
      vecs.push_back('{0, 1, 3, 0, 1, 0,   3, 0, 0});
      vecs.push_back('{0, 0, 0, 1, 1, 0,   4, 0, 0});
      vecs.push_back('{0, 0, 0, 0, 1, 0,   4, 0, 0});
      vecs.push_back('{0, 0, 0, 1, 1, 0,   5, 0, 0});
      vecs.push_back('{0, 1, 6, 0, 1, 0,   6, 0, 0});
      vecs.push_back('{1, 1, 5, 1, 1, 0,   0, 0, 0});
      vecs.push_back('{0, 0, 0, 1, 1, 0,   1, 0, 0});
      vecs.push_back('{0, 1, 1, 0, 0, 1,   1, 0, 0});
      vecs.push_back('{0, 0, 0, 1, 0, 1,   0, 0, 0});
      vecs.push_back('{0, 0, 0, 1, 0, 1,   0, 1, 1});
      vecs.push_back('{0, 0, 0, 1, 1, 1,   1, 0, 1});
      vecs.push_back('{0, 1, 4, 1, 1, 1,   4, 0, 0});
      foreach (vecs[i]) begin
         cycle(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up, vecs[i].sat);
         check($sformatf("vec%0d_count", i), 32'(count_b), 32'(vecs[i].cnt));
         check($sformatf("vec%0d_tc", i), 32'(tc_b), 32'(vecs[i].tc));
         check($sformatf("vec%0d_ovf", i), 32'(ovf_b), 32'(vecs[i].ovf));
      end

      // Full wrap of the 4-bit instance over 17 edges.
      cycle(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 17; i++) begin
         cycle(0, 0, 0, 1, 1, 0);
         check("wrap17_count", 32'(count_a), 32'((i + 1) % 16));
         check("wrap17_tc", 32'(tc_a), 32'(i == 15));
         check("wrap17_ovf", 32'(ovf_a), 32'(i >= 15));
      end
`else
      // Prescaled stepping: one step per PS enabled edges.
      cycle(1, 0, 0, 0, 1, 0);
      for (int e = 1; e <= 12; e++) begin
         cycle(0, 0, 0, 1, 1, 0);
         check("ps_count", 32'(count_a), 32'(e / PS));
      end
      // A load mid-phase restarts the prescale phase.
      cycle(1, 0, 0, 0, 1, 0);
      for (int e = 1; e <= 10; e++) begin
         cycle(0, (e == 6), 0, 1, 1, 0);
         check("ps_load_count", 32'(count_a), 32'((e == 4 || e == 5) ? 1 : (e == 10 ? 1 : 0)));
      end
`endif

      // Randomised stimulus checked against the model.
      for (int n = 0; n < 2000; n++) begin
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
               1'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
